// File: rtl/hilo_mac_reg.sv
// HI/LO special-register pair with a two-cycle multiply-accumulate path.
// Optional zero-cycle read-after-write forwarding: define HILO_BYPASS_EN.
module hilo_mac_reg #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  op_valid,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic [2*DATA_W-1:0]   prod_i,
  output logic                  stall_o,
  output logic                  acc_done_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  localparam logic [2:0] OP_WHI  = 3'b001;
  localparam logic [2:0] OP_WLO  = 3'b010;
  localparam logic [2:0] OP_WB   = 3'b011;
  localparam logic [2:0] OP_MADD = 3'b100;
  localparam logic [2:0] OP_MSUB = 3'b101;

  typedef enum logic {IDLE, ACC} state_t;

  state_t                state, state_nxt;
  logic [DATA_W-1:0]     hi_q, lo_q, hi_nxt, lo_nxt;
  logic [2*DATA_W-1:0]   pipe_q, pipe_nxt, acc_sum;
  logic                  acc_done_q, done_nxt;
  logic                  accept;

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    pipe_nxt  = pipe_q;
    done_nxt  = 1'b0;
    stall_o   = 1'b0;
    accept    = op_valid && !flush;
    acc_sum   = {hi_q, lo_q} + pipe_q;

    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_WHI: hi_nxt = hi_i;
            OP_WLO: lo_nxt = lo_i;
            OP_WB: begin
              hi_nxt = hi_i;
              lo_nxt = lo_i;
            end
            OP_MADD: begin
              pipe_nxt  = prod_i;
              state_nxt = ACC;
              stall_o   = 1'b1;
            end
            OP_MSUB: begin
              // subtract by accumulating the wrapped negation
              pipe_nxt  = -prod_i;
              state_nxt = ACC;
              stall_o   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ACC: begin
        // op inputs are still held by upstream here and must not re-issue
        state_nxt = IDLE;
        if (!flush) begin
          {hi_nxt, lo_nxt} = acc_sum;
          done_nxt         = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      pipe_q     <= '0;
      acc_done_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      hi_q       <= hi_nxt;
      lo_q       <= lo_nxt;
      pipe_q     <= pipe_nxt;
      acc_done_q <= done_nxt;
    end
  end

  assign acc_done_o = acc_done_q;

`ifdef HILO_BYPASS_EN
  // next-state values equal the registers for any half not written this cycle
  assign hi_o = hi_nxt;
  assign lo_o = lo_nxt;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: doc/hilo_mac_reg.md
Name: hilo_mac_reg

Overview:
- Parametrised HI/LO special-register unit for the MIPS core.
- Holds the 2*DATA_W HI:LO pair and supports HI-only, LO-only and paired writes (MTHI/MTLO/MULT/DIV results).
- Adds a two-cycle multiply-accumulate path (MADD/MADDU/MSUB/MSUBU) with a pipeline-stall handshake.
- Sits in the write-back stage. The multiplier upstream supplies the full-width product, already signed- or unsigned-extended.

Parameters:
DATA_W, 32, width of each of HI and LO; the accumulator is 2*DATA_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  pipeline flush; aborts an in-flight accumulate
op_valid  in  1  op is presented this cycle
op  in  3  000 NOP, 001 WHI, 010 WLO, 011 WBOTH, 100 MADD, 101 MSUB, 11x reserved (treated as NOP)
hi_i  in  DATA_W  HI write data for WHI/WBOTH
lo_i  in  DATA_W  LO write data for WLO/WBOTH
prod_i  in  2*DATA_W  product for MADD/MSUB
stall_o  out  1  stall request to the pipeline controller
acc_done_o  out  1  one-cycle pulse: accumulate result committed
hi_o  out  DATA_W  HI read value
lo_o  out  DATA_W  LO read value

Behaviour:
Reset:
- rst has priority over all other inputs, including mid-accumulate.
- On rst: hi, lo and the pipe register are set to 0; state goes to IDLE; acc_done_o=0.
- hi_o=0, lo_o=0 and stall_o=0 from the first cycle after the reset edge.

States: IDLE, ACC.

IDLE, op_valid=1:
- WHI: hi<=hi_i; lo unchanged.
- WLO: lo<=lo_i; hi unchanged.
- WBOTH: hi<=hi_i and lo<=lo_i in the same edge.
- MADD: pipe<=prod_i; go to ACC.
- MSUB: pipe<=two's-complement negation of prod_i (2*DATA_W wide, wraps); go to ACC.
- NOP or reserved: no change.

IDLE, op_valid=0: no change.

stall_o:
- Combinational: 1 iff state=IDLE, op_valid=1, op is MADD/MSUB and flush=0.
- 0 in ACC.
- While stall_o=1 the upstream holds op, hi_i, lo_i and prod_i stable.

ACC:
- Exactly one cycle.
- All op inputs are ignored; the held copy of the instruction is not re-issued.
- At the end of ACC: {hi,lo} <= {hi,lo} + pipe, modulo 2^(2*DATA_W), carry discarded. Then return to IDLE.
- acc_done_o is 1 in the cycle following the commit edge (registered pulse).

Latency:
- Writes: visible on hi_o/lo_o in the cycle after the write edge.
- Accumulates: visible 2 cycles after the accept cycle.

Flush:
- In IDLE: the op presented that cycle is discarded, with no write and no stall.
- In ACC: the accumulate is abandoned. No write, no acc_done_o, return to IDLE.

Back-to-back ops:
- An op presented in the first IDLE cycle after ACC is accepted normally, including another MADD.
- The second MADD accumulates onto the committed first result.

Register outputs:
- hi_o/lo_o reflect the registered hi/lo.
- The exception is when the optional bypass is compiled in.

Optional Feature:
Macro: HILO_BYPASS_EN

Defined:
- hi_o/lo_o are combinationally forwarded from the value being written this cycle.
- IDLE: hi_i on WHI/WBOTH, lo_i on WLO/WBOTH.
- ACC: the accumulate sum, unless flush=1.
- Forwarding is per half: a WHI forwards HI only, and LO shows the registered value.
- Gives zero-cycle read-after-write.

Undefined:
- hi_o/lo_o are the plain register outputs, one cycle behind.
- The pipeline forwards HI/LO externally.

Test Plan:
1. rst=1 for 2 cycles after WBOTH hi_i=0xDEADBEEF lo_i=0x12345678 -> hi_o=lo_o=0, stall_o=0, acc_done_o=0.
2. WHI 0xAAAA0001, then WLO 0x5555FFFF, then WBOTH 0x1/0x2 -> after each edge: HI changes only on WHI, LO only on WLO, both show 0x1/0x2 after WBOTH.
3. HI:LO=0x00000000_FFFFFFFF, MADD prod_i=0x1 held 2 cycles -> stall_o=1 in cycle 1 only, HI:LO=0x00000001_00000000, acc_done_o pulse once.
4. HI:LO=0, MSUB prod_i=0x1 -> HI:LO=0xFFFFFFFF_FFFFFFFF; then MADD prod_i=0x2 immediately -> 0x00000000_00000001.
5. MADD accepted, flush=1 in ACC cycle -> HI:LO unchanged, no acc_done_o; next WLO 0x7 accepted normally. Repeat with rst in ACC -> all zero.
6. With HILO_BYPASS_EN: WHI 0xCAFE0000 -> hi_o=0xCAFE0000 in the same cycle with lo_o unchanged. Without the macro, the value appears one cycle later.
